srcounter_seq: RTL and testbench
================================

Name: srcounter_seq

Overview:
- Initiator-side sequencer for the start/stop counter interface.
- Accepts a measurement command, issues a one-cycle start pulse, and monitors the counter's count value fed back on count_in.
- Issues a one-cycle stop pulse when the requested number of counts has elapsed, a timeout expires, or abort is asserted.
- Reports the elapsed count and completion status to the command side.

Parameters:
- CNT_W, 4, width of the counter value and of the target/result fields.
- TMO_W, 8, width of the cycle timeout field and of the internal cycle timer.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_target  input  CNT_W  counts to wait after start.
- cmd_timeout  input  TMO_W  max RUN cycles; 0 = no timeout.
- abort  input  1  force early stop while in RUN.
- count_in  input  CNT_W  current counter value.
- start  output  1  one-cycle start pulse to counter.
- stop  output  1  one-cycle stop pulse to counter.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  CNT_W  elapsed count, valid from done onward.
- status  output  2  00 = target reached, 01 = timeout, 10 = aborted; valid with done.

Behaviour:
- Reset (async, any state): FSM enters IDLE.
  - start, stop, done and busy are 0; cmd_ready is 1.
  - result, status, internal target, timeout, baseline and timer are 0.
- States: IDLE, START, RUN, STOP, DONE. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid is high at a rising edge, latch cmd_target, cmd_timeout and baseline <= count_in, then go to START.
  - cmd_ready is 0 in every other state; commands presented there are ignored, not queued.
- START:
  - start = 1 for exactly this cycle.
  - Timer cleared to 0.
  - Next state is RUN.
- RUN:
  - elapsed = (count_in - baseline) mod 2^CNT_W, so a counter wrap-around (e.g. F->0) is handled transparently.
  - Exit checks in priority order; the first match goes to STOP:
    1. abort = 1: status <= 10.
    2. elapsed == target: status <= 00.
    3. timeout != 0 and timer == timeout - 1: status <= 01.
  - On exit, result <= elapsed.
  - Otherwise stay in RUN with timer <= timer + 1. The timer saturates at all-ones and never wraps.
  - target = 0: the first RUN cycle satisfies elapsed == 0 only if count_in has not yet advanced; otherwise the block waits a full 2^CNT_W counts. This is the intended behaviour and is documented as such.
  - Targets of 2^CNT_W or more are not expressible.
  - Simultaneous abort and target match report aborted, but result still holds the true elapsed value.
- STOP:
  - stop = 1 for exactly this cycle.
  - Next state is DONE.
- DONE:
  - done = 1 for one cycle.
  - result and status hold until the next command is accepted.
  - Next state is IDLE. cmd_ready returns to 1 on the cycle after done.
- Latency:
  - Accept edge -> start high: 1 cycle.
  - Exit decision in RUN -> stop high: 1 cycle.
  - stop -> done: 1 cycle.
  - Minimum command-to-done: 4 cycles.
- start and stop are never high in the same cycle.
- start and stop are never high for two consecutive cycles.
- abort outside RUN has no effect.
- Reset asserted mid-operation: no stop pulse is emitted. The attached counter is assumed to share the same reset.
- count_in is sampled synchronously; it must be driven from the same clock domain.

Test Plan:
- Reset, then a command with target=3, timeout=0 and a counter model that increments 1 per cycle from 0 after start.
  - start pulses 1 cycle after accept; stop follows once elapsed reaches 3.
  - done has result=3, status=00.
  - The sequence start, stop, done is one cycle apart at each step.
- Baseline wrap: count_in=E at accept, counter increments, target=4.
  - Exit occurs at count_in=2; result=4, status=00.
- Timeout: counter frozen, target=5, timeout=6.
  - Exactly 6 RUN cycles elapse, then stop; done has status=01, result=0.
- Abort on the same cycle elapsed==target, with target=2.
  - status=10, result=2.
  - abort pulsed in IDLE or DONE: no change to outputs.
- Back-to-back commands: cmd_valid held high continuously.
  - Second command is accepted only on the cycle after done.
  - cmd_ready=0 throughout busy.
  - Two start pulses and two stop pulses total.
- Reset asserted mid-RUN.
  - Immediate return to IDLE; start, stop and done stay 0; result and status read 0.
  - A new command then completes normally.

Source files
------------

// File: rtl/srcounter_seq.sv
// Initiator-side sequencer for a start/stop counter: accepts a command, pulses start,
// watches count_in until target/timeout/abort, pulses stop, then reports result and status.
module srcounter_seq #(
  parameter int CNT_W = 4,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_target,
  input  logic [TMO_W-1:0] cmd_timeout,
  input  logic             abort,
  input  logic [CNT_W-1:0] count_in,
  output logic             start,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic [1:0]       status
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ST_TARGET  = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] baseline_q;
  logic [TMO_W-1:0] timeout_q;
  logic [TMO_W-1:0] timer_q;
  logic [CNT_W-1:0] elapsed;
  logic             run_exit;
  logic [1:0]       exit_status;

  // Modular difference makes a counter wrap between baseline and now invisible.
  assign elapsed = count_in - baseline_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    run_exit    = 1'b0;
    exit_status = ST_TARGET;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = START;
      START: state_nxt = RUN;
      RUN: begin
        if (abort) begin
          run_exit    = 1'b1;
          exit_status = ST_ABORT;
        end else if (elapsed == target_q) begin
          run_exit    = 1'b1;
          exit_status = ST_TARGET;
        end else if ((timeout_q != '0) && (timer_q == timeout_q - TMO_W'(1))) begin
          run_exit    = 1'b1;
          exit_status = ST_TIMEOUT;
        end
        if (run_exit) state_nxt = STOP;
      end
      STOP:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pulse outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start     <= 1'b0;
      stop      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      start     <= (state_nxt == START);
      stop      <= (state_nxt == STOP);
      done      <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      cmd_ready <= (state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q   <= '0;
      timeout_q  <= '0;
      baseline_q <= '0;
      timer_q    <= '0;
      result     <= '0;
      status     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            target_q   <= cmd_target;
            timeout_q  <= cmd_timeout;
            baseline_q <= count_in;
          end
        end
        START: timer_q <= '0;
        RUN: begin
          if (run_exit) begin
            result <= elapsed;
            status <= exit_status;
          end else if (timer_q != {TMO_W{1'b1}}) begin
            timer_q <= timer_q + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srcounter_seq.sv
// Randomised scoreboard bench for srcounter_seq: a plan-driven counter/abort model predicts
// each command's result, status and pulse timing; a negedge monitor checks what the DUT shows.
module tb_srcounter_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_target = 4'd0;
  logic [7:0] cmd_timeout = 8'd0;
  logic       abort = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       start, stop, busy, done;
  logic [3:0] result;
  logic [1:0] status;

  srcounter_seq #(.CNT_W(4), .TMO_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_timeout(cmd_timeout),
    .abort(abort), .count_in(count_in),
    .start(start), .stop(stop), .busy(busy), .done(done),
    .result(result), .status(status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [3:0] res;
    logic [1:0] st;
  } exp_t;

  exp_t done_q[$];
  int   start_q[$];
  int   stop_q[$];

  logic [3:0] cnt_plan [0:399];
  bit         ab_plan  [0:399];
  logic [3:0] last_res = 4'd0;
  logic [1:0] last_st  = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: pulse seen with nothing outstanding (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares each pulse the DUT produces with the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (start) begin
        check("start_stop_overlap", {31'd0, stop}, 32'd0);
        if (start_q.size() == 0) unexpected("start");
        else check("start_cycle", cyc, start_q.pop_front());
      end
      if (stop) begin
        if (stop_q.size() == 0) unexpected("stop");
        else check("stop_cycle", cyc, stop_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          exp_t e;
          e = done_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("result", {28'd0, result}, {28'd0, e.res});
          check("status", {30'd0, status}, {30'd0, e.st});
          check("busy_in_done", {31'd0, busy}, 32'd1);
          check("ready_in_done", {31'd0, cmd_ready}, 32'd0);
        end
      end
    end
  end

  // Reference: walk the RUN cycles of the plan and apply the exit rules in priority order.
  task automatic model(input logic [3:0] tgt, input logic [7:0] tmo, input logic [3:0] base,
                       output int len, output logic [3:0] res, output logic [1:0] st);
    len = 400;
    res = 4'd0;
    st  = 2'd0;
    for (int j = 0; j < 400; j++) begin
      logic [3:0] el;
      el = 4'(cnt_plan[j] - base);
      if (ab_plan[j]) begin
        len = j + 1; res = el; st = 2'b10; break;
      end else if (el == tgt) begin
        len = j + 1; res = el; st = 2'b00; break;
      end else if (tmo != 0 && j == int'(tmo) - 1) begin
        len = j + 1; res = el; st = 2'b01; break;
      end
    end
  endtask

  task automatic noise(input bit hold);
    if (!hold) begin
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_target = 4'($urandom_range(0, 15));
    end
  endtask

  // Caller guarantees the DUT will be in IDLE at the next rising edge.
  // mode: 0 = count +1 per RUN cycle, 1 = frozen, 2 = random steps.
  task automatic run_cmd(input logic [3:0] tgt, input logic [7:0] tmo, input logic [3:0] base,
                         input int mode, input int ab_j, input bit hold);
    int         len, e_cyc;
    logic [3:0] res;
    logic [1:0] st;
    logic [3:0] c;
    c = base;
    for (int j = 0; j < 400; j++) begin
      if (mode == 0) c = c + 4'd1;
      else if (mode == 2) c = c + ((j >= 100) ? 4'd1 : 4'($urandom_range(0, 1)));
      cnt_plan[j] = c;
      ab_plan[j]  = (j == ab_j);
    end
    model(tgt, tmo, base, len, res, st);

    cmd_valid   = 1'b1;
    cmd_target  = tgt;
    cmd_timeout = tmo;
    count_in    = base;
    abort       = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    e_cyc = cyc;
    start_q.push_back(e_cyc);
    stop_q.push_back(e_cyc + 1 + len);
    done_q.push_back('{cyc: e_cyc + 2 + len, res: res, st: st});
    last_res = res;
    last_st  = st;
    noise(hold);
    abort = 1'($urandom_range(0, 1));
    for (int j = 0; j < len; j++) begin
      @(posedge clk); #1;
      count_in = cnt_plan[j];
      abort    = ab_plan[j];
      noise(hold);
    end
    repeat (2) begin
      @(posedge clk); #1;
      abort = 1'($urandom_range(0, 1));
      noise(hold);
    end
    @(posedge clk); #1;
    abort     = 1'b0;
    cmd_valid = hold;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_start"},  {31'd0, start},     32'd0);
    check({tag, "_stop"},   {31'd0, stop},      32'd0);
    check({tag, "_done"},   {31'd0, done},      32'd0);
    check({tag, "_busy"},   {31'd0, busy},      32'd0);
    check({tag, "_ready"},  {31'd0, cmd_ready}, 32'd1);
    check({tag, "_result"}, {28'd0, result},    32'd0);
    check({tag, "_status"}, {30'd0, status},    32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    #3 check_idle_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    run_cmd(4'd3, 8'd0, 4'h0, 0, -1, 1'b0);   // basic: target 3, counter from 0
    run_cmd(4'd4, 8'd0, 4'hE, 0, -1, 1'b0);   // baseline wrap E -> 2
    run_cmd(4'd5, 8'd6, 4'h7, 1, -1, 1'b0);   // frozen counter, timeout 6
    run_cmd(4'd2, 8'd0, 4'h0, 0, 1, 1'b0);    // abort coincides with target match

    // abort while idle must leave result/status untouched
    cmd_valid = 1'b0;
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_abort_result", {28'd0, result}, {28'd0, last_res});
    check("idle_abort_status", {30'd0, status}, {30'd0, last_st});
    check("idle_abort_busy",   {31'd0, busy},   32'd0);
    abort = 1'b0;

    // reset while in RUN: no stop, everything cleared
    cmd_valid  = 1'b1;
    cmd_target = 4'd5;
    cmd_timeout = 8'd0;
    count_in   = 4'd3;
    @(posedge clk); #1;
    start_q.push_back(cyc);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_idle_zero("midrun_reset");
    @(posedge clk); #1 reset = 1'b0;

    run_cmd(4'd6, 8'd0, 4'h9, 0, -1, 1'b0);   // normal completion after reset

    run_cmd(4'd2, 8'd0, 4'h1, 0, -1, 1'b1);   // back-to-back, cmd_valid held
    run_cmd(4'd1, 8'd9, 4'h4, 2, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] t, b;
      logic [7:0] to;
      int         aj;
      t  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      to = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
      aj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_cmd(t, to, b, 2, aj, 1'b0);
    end

    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("start_q_empty", start_q.size(), 32'd0);
    check("stop_q_empty",  stop_q.size(),  32'd0);
    check("done_q_empty",  done_q.size(),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
